// File: rtl/floppy_test_pkg.sv
// Shared types and pattern arithmetic for the floppy bus bring-up generators.
// Patterns are computed on a MAX_WIDTH container and cut down to the bus width by the caller.
package floppy_test_pkg;

  typedef enum logic [1:0] {
    ALL_TOGGLE = 2'd0,
    WALK_ONE   = 2'd1,
    WALK_ZERO  = 2'd2,
    COUNT      = 2'd3
  } pattern_mode_t;

  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_WIDTH-1:0] pattern_t;

  function automatic pattern_t width_mask(input int width);
    pattern_t m;
    if (width >= MAX_WIDTH) begin
      m = '1;
    end else begin
      m = (pattern_t'(1'b1) << width) - pattern_t'(1'b1);
    end
    return m;
  endfunction

  function automatic pattern_t pattern_init(input pattern_mode_t mode, input int width);
    pattern_t v;
    case (mode)
      ALL_TOGGLE: v = '0;
      WALK_ONE:   v = pattern_t'(1'b1);
      WALK_ZERO:  v = width_mask(width) & ~pattern_t'(1'b1);
      COUNT:      v = '0;
      default:    v = '0;
    endcase
    return v;
  endfunction

  // value must already be confined to the low width bits for the rotate wrap to work
  function automatic pattern_t pattern_next(input pattern_mode_t mode, input pattern_t value,
                                            input int width);
    pattern_t mask;
    pattern_t v;
    mask = width_mask(width);
    case (mode)
      ALL_TOGGLE: v = ~value & mask;
      WALK_ONE:   v = ((value << 1) | (value >> (width - 1))) & mask;
      WALK_ZERO:  v = ((value << 1) | (value >> (width - 1))) & mask;
      COUNT:      v = (value + pattern_t'(1'b1)) & mask;
      default:    v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/floppy_bus_pattern_gen_step_divider.sv
// Free-running prescaler that flags the last clock of every HALF_PERIOD window.
// Holding clear parks the count at zero so the first window after release is a full one.
module step_divider #(
  parameter int HALF_PERIOD = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic step
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] presc_r;

  // prescaler count, wrapping on the last clock of each window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (clear) begin
      presc_r <= '0;
    end else if (presc_r == LAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + ONE;
    end
  end

  assign step = (presc_r == LAST);

endmodule

// File: rtl/floppy_bus_pattern_gen.sv
// Floppy bus bring-up pattern generator: drives every pin with a selectable pattern,
// stepping every HALF_PERIOD clocks, with a one-cycle tick on each step for scope triggering.
module floppy_bus_pattern_gen
  import floppy_test_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int HALF_PERIOD = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] bus,
  output logic             tick,
  output logic [1:0]       active_mode
);

  logic             run_r;
  logic             clear_s;
  logic             step_s;
  logic [WIDTH-1:0] init_s;
  logic [WIDTH-1:0] next_s;

  assign clear_s = ~enable | ~run_r;

  step_divider #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_step_divider (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear_s),
    .step (step_s)
  );

  // candidate pattern values: fresh start for the requested mode, or one step of the running one
  always_comb begin
    init_s = WIDTH'(pattern_init(pattern_mode_t'(mode), WIDTH));
    next_s = WIDTH'(pattern_next(pattern_mode_t'(active_mode), pattern_t'(bus), WIDTH));
  end

  // run control and pattern register; a dropped enable takes priority over any mode change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r       <= 1'b0;
      bus         <= '0;
      tick        <= 1'b0;
      active_mode <= 2'd0;
    end else if (!enable) begin
      run_r <= 1'b0;
      bus   <= '0;
      tick  <= 1'b0;
    end else if (!run_r) begin
      run_r       <= 1'b1;
      active_mode <= mode;
      bus         <= init_s;
      tick        <= 1'b0;
    end else if (step_s) begin
      tick <= 1'b1;
      if (mode == active_mode) begin
        bus <= next_s;
      end else begin
        active_mode <= mode;
        bus         <= init_s;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_floppy_bus_pattern_gen.sv
// Scoreboard bench for floppy_bus_pattern_gen at WIDTH=4, HALF_PERIOD=4.
// Stimulus queues hand-computed expectations tagged with the clock edge they apply to.
module tb_floppy_bus_pattern_gen;

  localparam int W  = 4;
  localparam int HP = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [1:0]   mode;
  logic [W-1:0] bus;
  logic         tick;
  logic [1:0]   active_mode;

  typedef struct {
    int           cyc;
    logic [W-1:0] bus;
    logic         tick;
    logic [1:0]   am;
    string        name;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] seq_q[$];
  int           cyc   = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  floppy_bus_pattern_gen #(
    .WIDTH      (W),
    .HALF_PERIOD(HP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .bus        (bus),
    .tick       (tick),
    .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every expectation due at the edge just taken
  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || bus !== e.bus || tick !== e.tick || active_mode !== e.am) begin
        n_bad++;
        $display("FAIL %s at edge %0d (due %0d): got bus=%b tick=%b active_mode=%0d, expected bus=%b tick=%b active_mode=%0d",
                 e.name, cyc, e.cyc, bus, tick, active_mode, e.bus, e.tick, e.am);
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [W-1:0] b, input logic t, input logic [1:0] m,
                      input string name);
    exp_t e;
    e.cyc = c; e.bus = b; e.tick = t; e.am = m; e.name = name;
    exp_q.push_back(e);
  endtask

  // start edge is the next edge; seq_q[k] is the bus value from edge e0+k*HP onward
  task automatic run_seq(input logic [1:0] m, input string name);
    int e0;
    int n;
    e0 = cyc + 1;
    n  = seq_q.size();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < HP; j++) begin
        if (k < n - 1 || j == 0) push(e0 + k * HP + j, seq_q[k], (k > 0 && j == 0), m, name);
      end
    end
    repeat (HP * (n - 1) + 1) step_clk();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0;
    repeat (2) step_clk();
    push(cyc, 4'b0000, 1'b0, 2'd0, "reset");
    rst_n = 1'b1;
    step_clk();
    push(cyc, 4'b0000, 1'b0, 2'd0, "idle_disabled");

    mode = 2'd0; enable = 1'b1;
    seq_q = {4'b0000, 4'b1111, 4'b0000};
    run_seq(2'd0, "all_toggle");
    enable = 1'b0; step_clk();
    push(cyc, 4'b0000, 1'b0, 2'd0, "disable_toggle");

    mode = 2'd1; enable = 1'b1;
    seq_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    run_seq(2'd1, "walk_one");
    enable = 1'b0; step_clk();
    push(cyc, 4'b0000, 1'b0, 2'd1, "disable_walk_one");

    mode = 2'd2; enable = 1'b1;
    seq_q = {4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    run_seq(2'd2, "walk_zero");
    enable = 1'b0; step_clk();
    push(cyc, 4'b0000, 1'b0, 2'd2, "disable_walk_zero");

    mode = 2'd3; enable = 1'b1;
    seq_q.delete();
    for (int v = 0; v < 16; v++) seq_q.push_back(4'(v));
    seq_q.push_back(4'b0000);
    run_seq(2'd3, "count");
    for (int i = 0; i < 3; i++) begin
      step_clk();
      push(cyc, 4'b0000, 1'b0, 2'd3, "count_tail");
    end
    enable = 1'b0; step_clk();
    push(cyc, 4'b0000, 1'b0, 2'd3, "disable_count");

    // one-cycle mode glitch is ignored; a held change lands on the boundary
    mode = 2'd1; enable = 1'b1;
    step_clk(); push(cyc, 4'b0001, 1'b0, 2'd1, "glitch_start");
    step_clk(); push(cyc, 4'b0001, 1'b0, 2'd1, "glitch_p1");
    mode = 2'd2;
    step_clk(); push(cyc, 4'b0001, 1'b0, 2'd1, "glitch_p2");
    mode = 2'd1;
    step_clk(); push(cyc, 4'b0001, 1'b0, 2'd1, "glitch_p3");
    step_clk(); push(cyc, 4'b0010, 1'b1, 2'd1, "glitch_step");
    mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      step_clk(); push(cyc, 4'b0010, 1'b0, 2'd1, "held_pending");
    end
    step_clk(); push(cyc, 4'b1110, 1'b1, 2'd2, "held_switch");
    step_clk(); push(cyc, 4'b1110, 1'b0, 2'd2, "after_switch");
    step_clk(); push(cyc, 4'b1110, 1'b0, 2'd2, "pre_drop");
    enable = 1'b0;
    step_clk(); push(cyc, 4'b0000, 1'b0, 2'd2, "drop_idle");

    enable = 1'b1;
    seq_q = {4'b1110, 4'b1101};
    run_seq(2'd2, "reenable");

    // asynchronous reset mid-step, observed before the next rising edge
    step_clk();
    #1 rst_n = 1'b0;
    push(cyc, 4'b0000, 1'b0, 2'd0, "async_reset");
    step_clk(); push(cyc, 4'b0000, 1'b0, 2'd0, "reset_held");
    mode = 2'd3;
    rst_n = 1'b1;
    seq_q = {4'b0000, 4'b0001, 4'b0010};
    run_seq(2'd3, "post_reset");

    repeat (2) step_clk();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
